// File: rtl/intdiv_seq_bbdiva_pkg.sv
// Shared types and helpers for the sequential restoring divider intdiv_seq_bbdiva.
// Latency helper counts cycles from the acceptance edge to out_valid.
package intdiv_seq_bbdiva_pkg;

   typedef struct packed {
      int unsigned loga;
      int unsigned logb;
      int unsigned unroll;
      int unsigned ff_out;
   } params_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic int unsigned intdiv_seq_bbdiva_lat(input params_t p);
      return 1 + (p.logb + p.unroll - 1) / p.unroll;
   endfunction

endpackage

// File: rtl/intdiv_seq_bbdiva_step.sv
// One combinational restoring-division step: shift a dividend bit into the
// remainder and conditionally subtract the divisor.
module intdiv_step #(
   parameter int unsigned LOGA = 34
) (
   input  logic [LOGA-1:0] i_rem,
   input  logic            i_bit,
   input  logic [LOGA-1:0] i_d,
   input  logic            i_en,
   output logic [LOGA-1:0] o_rem,
   output logic            o_qbit
);

   logic [LOGA:0] w_t;
   logic [LOGA:0] w_diff;
   logic          w_ge;

   assign w_t    = {i_rem, i_bit};
   assign w_diff = w_t - {1'b0, i_d};
   // With i_rem < i_d, t < 2*D: a negative difference always has its MSB set.
   assign w_ge   = ~w_diff[LOGA];

   always_comb begin
      o_rem  = i_rem;
      o_qbit = 1'b0;
      if (i_en) begin
         if (w_ge) begin
            o_rem  = w_diff[LOGA-1:0];
            o_qbit = 1'b1;
         end else begin
            o_rem  = w_t[LOGA-1:0];
         end
      end
   end

endmodule

// File: rtl/intdiv_seq_bbdiva.sv
// Sequential restoring divider: (LOGA+LOGB)-bit dividend / LOGA-bit divisor,
// LOGB-bit quotient, LOGA-bit remainder, valid/ready on both sides.
module intdiv_seq_bbdiva
   import intdiv_seq_bbdiva_pkg::*;
#(
   parameter int unsigned LOGA   = 34,
   parameter int unsigned LOGB   = 43,
   parameter int unsigned UNROLL = 1,
   parameter int unsigned FF_OUT = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [LOGA+LOGB-1:0] N,
   input  logic [LOGA-1:0]      D,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [LOGB-1:0]      Q,
   output logic [LOGA-1:0]      R,
   output logic                 ovf,
   output logic                 dz
);

   localparam int unsigned CW = $clog2(LOGB + UNROLL);

   state_t          r_state;
   state_t          w_state_nxt;
   logic [LOGA-1:0] r_rem;
   logic [LOGB-1:0] r_low;
   logic [LOGB-1:0] r_quo;
   logic [CW-1:0]   r_cnt;
   logic [LOGA-1:0] r_d;
   logic            r_ovf;
   logic            r_dz;

   logic [LOGA-1:0] w_hi;
   logic            w_ovf;
   logic [CW-1:0]   w_cnt_nxt;
   logic            w_last;
   logic [LOGA-1:0] w_rem [UNROLL+1];
   logic [LOGB-1:0] w_quo [UNROLL+1];
   logic [UNROLL-1:0] w_en;
   logic [UNROLL-1:0] w_qbit;

   assign w_hi      = N[LOGA+LOGB-1:LOGB];
   assign w_ovf     = (w_hi >= D);
   assign w_cnt_nxt = r_cnt + CW'(UNROLL);
   assign w_last    = (w_cnt_nxt >= CW'(LOGB));

   assign w_rem[0] = r_rem;
   assign w_quo[0] = r_quo;

   // Steps past LOGB are disabled so a partial final cycle leaves state untouched.
   for (genvar k = 0; k < UNROLL; k++) begin : g_step
      assign w_en[k] = ((r_cnt + CW'(k)) < CW'(LOGB));

      intdiv_step #(
         .LOGA (LOGA)
      ) u_step (
         .i_rem  (w_rem[k]),
         .i_bit  (r_low[LOGB-1-k]),
         .i_d    (r_d),
         .i_en   (w_en[k]),
         .o_rem  (w_rem[k+1]),
         .o_qbit (w_qbit[k])
      );

      assign w_quo[k+1] = w_en[k] ? {w_quo[k][LOGB-2:0], w_qbit[k]} : w_quo[k];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_state_nxt = w_ovf ? ST_DONE : ST_CALC;
            end
         end
         ST_CALC: begin
            if (w_last) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rem <= '0;
         r_low <= '0;
         r_quo <= '0;
         r_cnt <= '0;
         r_d   <= '0;
         r_ovf <= 1'b0;
         r_dz  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_d   <= D;
                  r_cnt <= '0;
                  r_quo <= '0;
                  r_ovf <= w_ovf;
                  r_dz  <= (D == '0);
                  if (w_ovf) begin
                     r_rem <= '0;
                     r_low <= '0;
                  end else begin
                     r_rem <= w_hi;
                     r_low <= N[LOGB-1:0];
                  end
               end
            end
            ST_CALC: begin
               r_rem <= w_rem[UNROLL];
               r_quo <= w_quo[UNROLL];
               r_low <= r_low << UNROLL;
               r_cnt <= w_cnt_nxt;
            end
            default: ;
         endcase
      end
   end

   assign ovf = r_ovf;
   assign dz  = r_dz;

   if (FF_OUT != 0) begin : g_ff_out
      logic [LOGB-1:0] r_q;
      logic [LOGA-1:0] r_r;

      always_ff @(posedge clk) begin
         if (rst) begin
            r_q <= '0;
            r_r <= '0;
         end else if (r_state == ST_CALC && w_last) begin
            r_q <= w_quo[UNROLL];
            r_r <= w_rem[UNROLL];
         end else if (r_state == ST_IDLE && in_valid && w_ovf) begin
            r_q <= '0;
            r_r <= '0;
         end
      end

      assign Q = r_q;
      assign R = r_r;
   end else begin : g_wire_out
      assign Q = r_quo;
      assign R = r_rem;
   end

endmodule

// File: tb/tb_intdiv_seq_bbdiva.sv
// Scoreboard bench for intdiv_seq_bbdiva: one UNROLL=1 registered-output unit
// and one UNROLL=4 unregistered-output unit sharing a clock.
module tb_intdiv_seq_bbdiva;
   import intdiv_seq_bbdiva_pkg::*;

   localparam int unsigned LA = 34;
   localparam int unsigned LB = 43;
   localparam params_t P0 = '{LA, LB, 1, 1};
   localparam params_t P1 = '{LA, LB, 4, 0};

   typedef struct {
      logic [LB-1:0] q;
      logic [LA-1:0] r;
      logic          ovf;
      logic          dz;
      int unsigned   lat;
   } exp_t;

   exp_t sb[$];

   logic          clk = 1'b0;
   logic          rst;
   logic          iv   [2];
   logic          ir   [2];
   logic          ov   [2];
   logic          ordy [2];
   logic [LA+LB-1:0] n_s [2];
   logic [LA-1:0] d_s  [2];
   logic [LB-1:0] q_s  [2];
   logic [LA-1:0] r_s  [2];
   logic          ovf_s[2];
   logic          dz_s [2];

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   always #5 clk = ~clk;

   intdiv_seq_bbdiva #(
      .LOGA(LA), .LOGB(LB), .UNROLL(1), .FF_OUT(1)
   ) u_dut0 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .N(n_s[0]), .D(d_s[0]),
      .out_valid(ov[0]), .out_ready(ordy[0]), .Q(q_s[0]), .R(r_s[0]), .ovf(ovf_s[0]), .dz(dz_s[0])
   );

   intdiv_seq_bbdiva #(
      .LOGA(LA), .LOGB(LB), .UNROLL(4), .FF_OUT(0)
   ) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .N(n_s[1]), .D(d_s[1]),
      .out_valid(ov[1]), .out_ready(ordy[1]), .Q(q_s[1]), .R(r_s[1]), .ovf(ovf_s[1]), .dz(dz_s[1])
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
      n_chk++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
   endtask

   // Drive one operation on unit u, then pop and compare its result.
   task automatic do_op(input int u, input logic [LA+LB-1:0] n, input logic [LA-1:0] d,
                        input logic [LB-1:0] q, input logic [LA-1:0] r,
                        input logic eovf, input logic edz, input int hold);
      exp_t e;
      int unsigned cyc;
      cyc = 0;
      while (!ir[u] && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      chk("in_ready", ir[u], 1);
      e.q = q; e.r = r; e.ovf = eovf; e.dz = edz;
      e.lat = eovf ? 1 : intdiv_seq_bbdiva_lat(u == 0 ? P0 : P1);
      sb.push_back(e);
      ordy[u] = (hold == 0);
      n_s[u] = n; d_s[u] = d; iv[u] = 1'b1;
      @(negedge clk);
      iv[u] = 1'b0;
      cyc = 1;
      while (!ov[u] && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      e = sb.pop_front();
      chk("latency", cyc, e.lat);
      chk("q", q_s[u], e.q);
      chk("r", r_s[u], e.r);
      chk("ovf", ovf_s[u], e.ovf);
      chk("dz", dz_s[u], e.dz);
      for (int i = 0; i < hold; i++) begin
         if (i == 2) begin
            n_s[u] = 77'd999; d_s[u] = 34'd2; iv[u] = 1'b1;
         end
         @(negedge clk);
         iv[u] = 1'b0;
         chk("bp_valid", ov[u], 1);
         chk("bp_in_ready", ir[u], 0);
         chk("bp_q", q_s[u], e.q);
         chk("bp_r", r_s[u], e.r);
      end
      ordy[u] = 1'b1;
      @(negedge clk);
      chk("valid_drop", ov[u], 0);
      chk("idle_ready", ir[u], 1);
   endtask

   initial begin
      logic [LA+LB-1:0] big;
      logic [LA+LB-1:0] na;
      logic [LA+LB-1:0] nb;
      logic [LA+LB-1:0] nr;
      logic [63:0]      rnd;

      rst = 1'b1;
      for (int u = 0; u < 2; u++) begin
         iv[u] = 1'b0; ordy[u] = 1'b1; n_s[u] = '0; d_s[u] = '0;
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         chk("rst_in_ready", ir[u], 1);
         chk("rst_out_valid", ov[u], 0);
         chk("rst_q", q_s[u], 0);
         chk("rst_r", r_s[u], 0);
         chk("rst_ovf", ovf_s[u], 0);
         chk("rst_dz", dz_s[u], 0);
      end

      do_op(0, 77'd1000, 34'd7, 43'd142, 34'd6, 1'b0, 1'b0, 0);
      big = ((77'(1) << 34) - 77'd1) * ((77'(1) << 43) - 77'd1);
      do_op(0, big, 34'h3_FFFF_FFFF, 43'h7FF_FFFF_FFFF, 34'd0, 1'b0, 1'b0, 0);
      do_op(0, 77'(1) << 43, 34'd1, 43'd0, 34'd0, 1'b1, 1'b0, 0);
      do_op(0, 77'd5, 34'd0, 43'd0, 34'd0, 1'b1, 1'b1, 0);
      do_op(0, 77'd123456789, 34'd1000, 43'd123456, 34'd789, 1'b0, 1'b0, 5);

      // Abandon an operation mid-calculation with reset.
      n_s[0] = 77'd1000; d_s[0] = 34'd7; iv[0] = 1'b1;
      @(negedge clk);
      iv[0] = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_in_ready", ir[0], 1);
      chk("midrst_out_valid", ov[0], 0);
      do_op(0, 77'd1000, 34'd7, 43'd142, 34'd6, 1'b0, 1'b0, 0);

      do_op(1, 77'd1000, 34'd7, 43'd142, 34'd6, 1'b0, 1'b0, 0);
      do_op(1, 77'(1) << 76, 34'(1) << 33, 43'd0, 34'd0, 1'b1, 1'b0, 0);
      do_op(1, (77'(1) << 75) + 77'd3, 34'(1) << 33, 43'(1) << 42, 34'd3, 1'b0, 1'b0, 0);
      do_op(1, 77'd5, 34'd0, 43'd0, 34'd0, 1'b1, 1'b1, 2);

      // Multiplier inverse: N = A*B + r, r < A.
      for (int i = 0; i < 400; i++) begin
         rnd = {$urandom, $urandom};
         na  = 77'(rnd[LA-1:0] >> $urandom_range(0, LA - 1));
         if (na == '0) na = 77'd1;
         rnd = {$urandom, $urandom};
         nb  = 77'(rnd[LB-1:0]);
         if (i == 0) nb = 77'(43'h7FF_FFFF_FFFF);
         rnd = {$urandom, $urandom};
         nr  = 77'(rnd) % na;
         do_op(i % 4 == 0 ? 0 : 1, na * nb + nr, na[LA-1:0], nb[LB-1:0], nr[LA-1:0],
               1'b0, 1'b0, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
